sysarray_seq_ctrl: RTL and testbench
====================================

Name: sysarray_seq_ctrl

Overview:
Sequencer for the sysarray datapath. It buffers two n x n operand matrices (A rows feeding arr1, B rows feeding arr2) through a valid/ready load port. On start, it drives sysarray's flg step counter and packed row buses cycle-by-cycle. It replaces hand-driven flg/arr stimulus, so sysarray can sit behind a host or DMA front end.

Parameters:
N, 31, MSB index of one element; element width is N+1 bits.
n, 5, array dimension (rows per matrix, elements per row).
FLG_W, 7, width of flg; must satisfy 3n-2 < 2**FLG_W.
LAST_STEP (localparam), 3*n-2, final flg value of a run.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  load row offered.
in_ready  out  1  controller can accept a load row.
in_row_a  in  (N+1)*n  packed A row; element j at bits [(j+1)(N+1)-1 : j(N+1)].
in_row_b  in  (N+1)*n  packed B row, same packing.
start  in  1  single-cycle request to run a loaded pair.
busy  out  1  high in RUN.
loaded  out  1  high in READY (full matrix pair buffered).
done  out  1  one-cycle pulse at end of run.
flg  out  FLG_W  step index to sysarray.flg.
arr1  out  (N+1)*n  row bus to sysarray.arr1.
arr2  out  (N+1)*n  row bus to sysarray.arr2.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, write pointer=0, flg=0, arr1=arr2=0, busy=loaded=done=0, in_ready=0 while asserted. Buffer contents are don't-care after reset.
- States: IDLE, LOAD, READY, RUN, DONE. All outputs are registered.
- in_ready=1 in IDLE and LOAD only.
- A beat is accepted when in_valid & in_ready at a rising edge.
  - Beat k writes A row k and B row k; the pointer increments.
- IDLE -> LOAD on the first accepted beat.
- LOAD -> READY on the edge accepting beat n-1; the pointer wraps to 0.
- n=1: IDLE -> READY directly.
- READY: loaded=1; holds indefinitely. start -> RUN.
- start outside READY is ignored (no queuing), including during LOAD, RUN and DONE.
- Entering RUN at edge E0: flg<=0, arr1<=A row0, arr2<=B row0, busy<=1. sysarray therefore samples step 0 at edge E0+1.
- In RUN, each edge: flg<=flg+1.
  - arr1/arr2 <= buffered row[flg+1] when flg+1 < n, else all zeros (drain).
- RUN -> DONE on the edge where flg==LAST_STEP. At that edge: flg<=0, arr1=arr2<=0, busy<=0, done<=1.
- RUN length is exactly LAST_STEP+1 cycles; flg never exceeds LAST_STEP.
- DONE lasts one cycle; done deasserts and the state returns to IDLE. The buffer is not reused; a new pair must be loaded.
- Outside RUN: flg=0 and arr1=arr2=0.
- in_valid in READY, RUN or DONE is not accepted (in_ready=0); no buffer write occurs.
- rst_n low mid-LOAD or mid-RUN:
  - all outputs clear immediately (asynchronously);
  - the partial load is discarded;
  - after release, the block is in IDLE.
- Element values pass through unmodified; no arithmetic on data.

Decomposition:
- Package sysarray_pkg holds:
  - N, n, FLG_W, LAST_STEP;
  - the state enum (IDLE, LOAD, READY, RUN, DONE);
  - a row-width constant ROW_W=(N+1)*n.
- Sub-module sysarray_row_buf: n-entry x ROW_W register file, one write port (wr_en, wr_idx, wr_data) and one combinational read port (rd_idx).
  - Instantiate it twice (A and B).
  - The controller FSM, pointer and flg counter stay in sysarray_seq_ctrl.

Test Plan:
1. Reset then normal load: hold in_valid, load rows A=B={1..5},{6..10},{11..15},{16..20},{21..25} (element j of row r = 5r+j+1). Required: in_ready high for 5 beats, then loaded=1 and in_ready=0 the next cycle.
2. Run sequence: pulse start in READY. Required:
   - flg steps 0,1,...,13 over 14 consecutive cycles; busy high throughout.
   - arr1 = row with elements 1..5 (element 0 = 1) at flg=0, elements 21..25 at flg=4.
   - arr1 = arr2 = 0 for flg=5..13.
   - done=1 for exactly one cycle after flg=13, then flg=0, busy=0.
3. Backpressure gaps: toggle in_valid 1,0,1,0 between beats. Required: only beats with in_valid&in_ready are stored; a run reproduces rows 1..25 exactly with no duplicates or skips.
4. Illegal start/in_valid: start during LOAD after 2 beats, start during RUN, in_valid during RUN. Required: no state change, flg sequence unaffected, buffer unmodified.
5. Reset mid-run: drop rst_n at flg=7. Required: flg, arr1, arr2, busy clear in the same cycle without waiting for clk. After release: in_ready=1 with state IDLE; start ignored until 5 new beats are loaded.
6. Back-to-back jobs: load pair X, run, load pair Y (elements 100+k), run. Required: the second run presents only Y rows and flg restarts at 0.

Source files
------------

// File: rtl/sysarray_pkg.sv
// sysarray_pkg
// Shared constants and types for the sysarray sequencer slice.
//   N         : MSB index of one element (element width N+1)
//   n         : array dimension (rows per matrix, elements per row)
//   FLG_W     : width of the sysarray step index flg
//   LAST_STEP : final flg value of a run (3n-2)
//   ROW_W     : width of one packed row bus
//   PTR_W     : width of a row index into the operand buffers
package sysarray_pkg;

  localparam int N         = 31;
  localparam int n         = 5;
  localparam int FLG_W     = 7;
  localparam int LAST_STEP = 3*n - 2;
  localparam int ROW_W     = (N+1)*n;
  localparam int PTR_W     = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/sysarray_row_buf.sv
// sysarray_row_buf
// Small register file holding one operand matrix, one row per entry.
// Ports:
//   clk     in  clock; writes happen on the rising edge
//   wr_en   in  write strobe
//   wr_idx  in  row index to write
//   wr_data in  packed row to store
//   rd_idx  in  row index to read
//   rd_data out packed row at rd_idx (combinational)
// Contents are not reset; the sequencer never reads a row it has not written.
module sysarray_row_buf
  import sysarray_pkg::*;
#(
  parameter int DEPTH = n,
  parameter int WIDTH = ROW_W,
  parameter int IDX_W = PTR_W
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_idx) < DEPTH)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Out-of-range indices can only arise for non-power-of-two depths; read zero.
  assign rd_data = (int'(rd_idx) < DEPTH) ? mem[rd_idx] : '0;

endmodule

// File: rtl/sysarray_seq_ctrl.sv
// sysarray_seq_ctrl
// Buffers an A/B operand matrix pair through a valid/ready load port, then on
// start drives sysarray's flg step counter and arr1/arr2 row buses.
// Ports:
//   clk       in  clock
//   rst_n     in  asynchronous active-low reset
//   in_valid  in  load row offered
//   in_ready  out controller can accept a load row (IDLE/LOAD)
//   in_row_a  in  packed A row
//   in_row_b  in  packed B row
//   start     in  run request, honoured only when loaded
//   busy      out high while running
//   loaded    out high while a full pair is buffered
//   done      out one-cycle pulse at end of run
//   flg       out step index to sysarray
//   arr1      out A row bus to sysarray
//   arr2      out B row bus to sysarray
module sysarray_seq_ctrl
  import sysarray_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_row_a,
  input  logic [ROW_W-1:0] in_row_b,
  input  logic             start,
  output logic             busy,
  output logic             loaded,
  output logic             done,
  output logic [FLG_W-1:0] flg,
  output logic [ROW_W-1:0] arr1,
  output logic [ROW_W-1:0] arr2
);

  state_t             state;
  state_t             state_nx;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   wr_ptr_nx;
  logic [PTR_W-1:0]   rd_idx;
  logic [FLG_W-1:0]   flg_nx;
  logic [FLG_W-1:0]   flg_inc;
  logic [ROW_W-1:0]   arr1_nx;
  logic [ROW_W-1:0]   arr2_nx;
  logic [ROW_W-1:0]   row_a;
  logic [ROW_W-1:0]   row_b;
  logic               accept;
  logic               last_beat;
  logic               last_step;
  logic               step_in_rows;

  assign accept       = in_valid & in_ready;
  assign last_beat    = (wr_ptr == PTR_W'(n-1));
  assign flg_inc      = flg + FLG_W'(1);
  assign last_step    = (flg == FLG_W'(LAST_STEP));
  assign step_in_rows = (flg_inc < FLG_W'(n));

  // Outside RUN the read index sits at row 0, so the READY->RUN edge loads
  // row 0 directly; in RUN it looks one step ahead of the registered flg.
  always_comb begin
    rd_idx = '0;
    if (state == RUN && step_in_rows) begin
      rd_idx = flg_inc[PTR_W-1:0];
    end
  end

  sysarray_row_buf u_buf_a (
    .clk     (clk),
    .wr_en   (accept),
    .wr_idx  (wr_ptr),
    .wr_data (in_row_a),
    .rd_idx  (rd_idx),
    .rd_data (row_a)
  );

  sysarray_row_buf u_buf_b (
    .clk     (clk),
    .wr_en   (accept),
    .wr_idx  (wr_ptr),
    .wr_data (in_row_b),
    .rd_idx  (rd_idx),
    .rd_data (row_b)
  );

  // Next state plus next values of the registered outputs. Row buses and flg
  // default to zero, so they only carry data while entering or inside RUN.
  always_comb begin
    state_nx  = state;
    wr_ptr_nx = wr_ptr;
    flg_nx    = '0;
    arr1_nx   = '0;
    arr2_nx   = '0;

    if (accept) begin
      wr_ptr_nx = last_beat ? '0 : wr_ptr + PTR_W'(1);
    end

    case (state)
      IDLE: begin
        // With n=1 the first beat is also the last, going straight to READY.
        if (accept) begin
          state_nx = last_beat ? READY : LOAD;
        end
      end
      LOAD: begin
        if (accept && last_beat) begin
          state_nx = READY;
        end
      end
      READY: begin
        if (start) begin
          state_nx = RUN;
          arr1_nx  = row_a;
          arr2_nx  = row_b;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nx = DONE;
        end else begin
          flg_nx = flg_inc;
          if (step_in_rows) begin
            arr1_nx = row_a;
            arr2_nx = row_b;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they line up with the
  // registered state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      flg      <= '0;
      arr1     <= '0;
      arr2     <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      loaded   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      wr_ptr   <= wr_ptr_nx;
      flg      <= flg_nx;
      arr1     <= arr1_nx;
      arr2     <= arr2_nx;
      in_ready <= (state_nx == IDLE) || (state_nx == LOAD);
      busy     <= (state_nx == RUN);
      loaded   <= (state_nx == READY);
      done     <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_sysarray_seq_ctrl.sv
// tb_sysarray_seq_ctrl
// Self-checking bench for sysarray_seq_ctrl. Loads operand pairs, records the
// expected flg/arr1/arr2 sequence in a scoreboard queue when start is issued,
// and pops one entry per busy cycle to compare against the DUT.
module tb_sysarray_seq_ctrl;
  import sysarray_pkg::*;

  localparam int EW = N + 1;

  typedef struct {
    logic [FLG_W-1:0] flg;
    logic [ROW_W-1:0] a;
    logic [ROW_W-1:0] b;
  } step_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_row_a;
  logic [ROW_W-1:0] in_row_b;
  logic             start;
  logic             busy;
  logic             loaded;
  logic             done;
  logic [FLG_W-1:0] flg;
  logic [ROW_W-1:0] arr1;
  logic [ROW_W-1:0] arr2;

  step_t            sbQueue[$];
  logic [ROW_W-1:0] expA [n];
  logic [ROW_W-1:0] expB [n];
  int               vectorCount = 0;
  int               failCount   = 0;

  sysarray_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row_a (in_row_a),
    .in_row_b (in_row_b),
    .start    (start),
    .busy     (busy),
    .loaded   (loaded),
    .done     (done),
    .flg      (flg),
    .arr1     (arr1),
    .arr2     (arr2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [ROW_W-1:0] observed,
                             input logic [ROW_W-1:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  function automatic logic [ROW_W-1:0] makeRow(input int base);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[j*EW +: EW] = EW'(base + j);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] randRow();
    logic [ROW_W-1:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[j*EW +: EW] = EW'($urandom);
    return r;
  endfunction

  // Loads one pair: A row r = aOff+n*r+j, B row r = bOff+n*r+j. Optional idle
  // gaps carry garbage with in_valid low; optional start pulse mid-load.
  task automatic applyStimulus(input int aOff, input int bOff, input bit gaps,
                               input bit startMid);
    for (int r = 0; r < n; r++) begin
      if (gaps && r > 0) begin
        in_valid = 1'b0;
        in_row_a = randRow();
        in_row_b = randRow();
        @(negedge clk);
      end
      if (startMid && r == 2) begin
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("load_start_loaded", ROW_W'(loaded), ROW_W'(0));
        checkOutput("load_start_busy", ROW_W'(busy), ROW_W'(0));
        checkOutput("load_start_ready", ROW_W'(in_ready), ROW_W'(1));
      end
      checkOutput("load_ready", ROW_W'(in_ready), ROW_W'(1));
      expA[r]  = makeRow(aOff + n*r);
      expB[r]  = makeRow(bOff + n*r);
      in_valid = 1'b1;
      in_row_a = expA[r];
      in_row_b = expB[r];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_row_a = randRow();
    in_row_b = randRow();
    checkOutput("loaded", ROW_W'(loaded), ROW_W'(1));
    checkOutput("ready_after_load", ROW_W'(in_ready), ROW_W'(0));
  endtask

  // Issues start, pushes the expected step sequence, then pops and compares
  // one entry per busy cycle. Optionally injects illegal start/in_valid, or
  // drops rst_n once flg reaches resetAt.
  task automatic runJob(input bit inject, input int resetAt);
    step_t e;
    bit    aborted;
    int    guard;
    aborted = 1'b0;
    guard   = 0;
    start   = 1'b1;
    for (int s = 0; s <= LAST_STEP; s++) begin
      e.flg = FLG_W'(s);
      e.a   = (s < n) ? expA[s] : '0;
      e.b   = (s < n) ? expB[s] : '0;
      sbQueue.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && guard < LAST_STEP + 10 && !aborted) begin
      guard++;
      if (sbQueue.size() == 0) begin
        checkOutput("sb_underflow", ROW_W'(1), ROW_W'(0));
        break;
      end
      e = sbQueue.pop_front();
      checkOutput("flg", ROW_W'(flg), ROW_W'(e.flg));
      checkOutput("arr1", arr1, e.a);
      checkOutput("arr2", arr2, e.b);
      start    = 1'b0;
      in_valid = 1'b0;
      if (inject && (e.flg == FLG_W'(0) || e.flg == FLG_W'(2))) begin
        checkOutput("run_ready", ROW_W'(in_ready), ROW_W'(0));
        start    = 1'b1;
        in_valid = 1'b1;
        in_row_a = randRow();
        in_row_b = randRow();
      end
      if (resetAt >= 0 && e.flg == FLG_W'(resetAt)) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_flg", ROW_W'(flg), ROW_W'(0));
        checkOutput("rst_arr1", arr1, '0);
        checkOutput("rst_arr2", arr2, '0);
        checkOutput("rst_busy", ROW_W'(busy), ROW_W'(0));
        sbQueue.delete();
        aborted = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (!aborted) begin
      checkOutput("sb_left", ROW_W'(sbQueue.size()), ROW_W'(0));
      checkOutput("done", ROW_W'(done), ROW_W'(1));
      checkOutput("done_flg", ROW_W'(flg), ROW_W'(0));
      checkOutput("done_busy", ROW_W'(busy), ROW_W'(0));
      checkOutput("done_arr1", arr1, '0);
      @(negedge clk);
      checkOutput("done_pulse", ROW_W'(done), ROW_W'(0));
      checkOutput("idle_ready", ROW_W'(in_ready), ROW_W'(1));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    start    = 1'b0;
    in_row_a = '0;
    in_row_b = '0;

    #12;
    checkOutput("rst_in_ready", ROW_W'(in_ready), ROW_W'(0));
    checkOutput("rst_busy", ROW_W'(busy), ROW_W'(0));
    checkOutput("rst_loaded", ROW_W'(loaded), ROW_W'(0));
    checkOutput("rst_done", ROW_W'(done), ROW_W'(0));
    checkOutput("rst_flg", ROW_W'(flg), ROW_W'(0));
    checkOutput("rst_arr1", arr1, '0);
    checkOutput("rst_arr2", arr2, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", ROW_W'(in_ready), ROW_W'(1));

    $display("[TB] normal load and run");
    applyStimulus(1, 1, 1'b0, 1'b0);
    runJob(1'b0, -1);

    $display("[TB] backpressure gaps");
    applyStimulus(1, 1001, 1'b1, 1'b0);
    runJob(1'b0, -1);

    $display("[TB] illegal start and in_valid");
    applyStimulus(1, 501, 1'b0, 1'b1);
    runJob(1'b1, -1);

    $display("[TB] reset mid-run");
    applyStimulus(1, 1, 1'b0, 1'b0);
    runJob(1'b0, 7);
    @(negedge clk);
    checkOutput("rel_ready", ROW_W'(in_ready), ROW_W'(1));
    checkOutput("rel_loaded", ROW_W'(loaded), ROW_W'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rel_start_busy", ROW_W'(busy), ROW_W'(0));
    checkOutput("rel_start_loaded", ROW_W'(loaded), ROW_W'(0));
    applyStimulus(201, 301, 1'b0, 1'b0);
    runJob(1'b0, -1);

    $display("[TB] back-to-back jobs");
    applyStimulus(1, 1, 1'b0, 1'b0);
    runJob(1'b0, -1);
    applyStimulus(100, 100, 1'b0, 1'b0);
    runJob(1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
